// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART/ALU frame interface.
// Provides FSM state encodings, ALU opcode constants, default widths
// and a small helper for classifying busy states.
package uart_alu_pkg;

    localparam int unsigned NB_DATA_DEF = 8;
    localparam int unsigned NB_OP_DEF   = 6;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;
    localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;

    // States in which an incoming byte cannot be accepted.
    function automatic logic is_busy(input state_t s);
        return (s == EXEC) || (s == SEND) || (s == WAIT_TX);
    endfunction

    // States in which a partially received frame is being timed.
    function automatic logic is_mid_frame(input state_t s);
        return (s == WAIT_B) || (s == WAIT_OP);
    endfunction

endpackage

// File: rtl/uart_alu_if_frame_timer.sv
// Inter-byte idle timer for frame assembly.
// Ports: clk, reset (sync, active-low), clear (zero the count),
// enable (count this cycle), expired (combinational pulse when the
// count sits at TIMEOUT_CYCLES-1 with enable high).
module frame_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Expiry is combinational so the FSM can leave in the same cycle.
    assign expired = enable && (count == LAST);

    // Count clears on expiry, so it never passes LAST and never wraps.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || expired) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_alu_if.sv
// Frame assembly and result return between uart_rx, the ALU and uart_tx.
// Collects A, B and opcode bytes, holds them on the ALU inputs, captures
// the result, pulses tx_start and waits for tx_done_tick. Partial frames
// are dropped after TIMEOUT_CYCLES idle cycles.
// Ports: clk, reset (sync, active-low), rx_done_tick/rx_data (byte in),
// alu_result (ALU output), tx_done_tick (transmit finished),
// o_data_a/o_data_b/o_op (ALU operands), tx_start/tx_data (to uart_tx),
// o_timeout (frame dropped pulse), o_overrun (sticky byte-while-busy flag).
module uart_alu_if
    import uart_alu_pkg::*;
#(
    parameter int unsigned NB_DATA        = NB_DATA_DEF,
    parameter int unsigned NB_OP          = NB_OP_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_done_tick,
    input  logic [NB_DATA-1:0] rx_data,
    input  logic [NB_DATA-1:0] alu_result,
    input  logic               tx_done_tick,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    output logic               tx_start,
    output logic [NB_DATA-1:0] tx_data,
    output logic               o_timeout,
    output logic               o_overrun
);

    state_t state, state_nxt;

    logic [NB_DATA-1:0] data_a_nxt, data_b_nxt, tx_data_nxt;
    logic [NB_OP-1:0]   op_nxt;
    logic               tx_start_nxt, timeout_nxt, overrun_nxt;

    logic timer_clear, timer_enable, timer_expired;

    // Timer runs only between bytes of a partial frame; a byte restarts it.
    assign timer_enable = is_mid_frame(state) && !rx_done_tick;
    assign timer_clear  = !is_mid_frame(state) || rx_done_tick;

    frame_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= WAIT_A;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next values of all registered outputs.
    always_comb begin
        state_nxt    = state;
        data_a_nxt   = o_data_a;
        data_b_nxt   = o_data_b;
        op_nxt       = o_op;
        tx_data_nxt  = tx_data;
        tx_start_nxt = 1'b0;
        timeout_nxt  = 1'b0;
        overrun_nxt  = o_overrun || (rx_done_tick && is_busy(state));

        case (state)
            WAIT_A: begin
                if (rx_done_tick) begin
                    data_a_nxt = rx_data;
                    state_nxt  = WAIT_B;
                end
            end
            WAIT_B: begin
                if (rx_done_tick) begin
                    data_b_nxt = rx_data;
                    state_nxt  = WAIT_OP;
                end else if (timer_expired) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (rx_done_tick) begin
                    op_nxt    = rx_data[NB_OP-1:0];
                    state_nxt = EXEC;
                end else if (timer_expired) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = WAIT_A;
                end
            end
            EXEC: begin
                // tx_start is raised for the SEND cycle that follows.
                tx_data_nxt  = alu_result;
                tx_start_nxt = 1'b1;
                state_nxt    = SEND;
            end
            SEND: begin
                state_nxt = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done_tick) begin
                    state_nxt = WAIT_A;
                end
            end
            default: begin
                state_nxt = WAIT_A;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            o_data_a  <= '0;
            o_data_b  <= '0;
            o_op      <= '0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            o_timeout <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_data_a  <= data_a_nxt;
            o_data_b  <= data_b_nxt;
            o_op      <= op_nxt;
            tx_data   <= tx_data_nxt;
            tx_start  <= tx_start_nxt;
            o_timeout <= timeout_nxt;
            o_overrun <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_uart_alu_if.sv
// Self-checking bench for uart_alu_if with a behavioural ALU model.
module tb_uart_alu_if;
    import uart_alu_pkg::*;

    localparam int unsigned TO = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] alu_result;
    logic       tx_done_tick = 1'b0;
    logic [7:0] o_data_a, o_data_b, tx_data;
    logic [5:0] o_op;
    logic       tx_start, o_timeout, o_overrun;

    int errors = 0;
    int checks = 0;

    uart_alu_if #(
        .NB_DATA        (8),
        .NB_OP          (6),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .alu_result   (alu_result),
        .tx_done_tick (tx_done_tick),
        .o_data_a     (o_data_a),
        .o_data_b     (o_data_b),
        .o_op         (o_op),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .o_timeout    (o_timeout),
        .o_overrun    (o_overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        logic signed [7:0] sa;
        sa = a;
        case (op)
            OP_ADD:  return 8'(a + b);
            OP_SUB:  return 8'(a - b);
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SRA:  return 8'(sa >>> b);
            OP_SRL:  return a >> b;
            OP_NOR:  return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    always_comb alu_result = alu_model(o_data_a, o_data_b, o_op);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge; the byte is seen at the next rising edge.
    task automatic pulse_rx(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    task automatic pulse_tx_done();
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
    endtask

    // Called one falling edge after the opcode byte (state EXEC).
    task automatic finish_frame(input string name, input logic [7:0] ea, input logic [7:0] eb,
                                input logic [5:0] eop, input logic [7:0] etx);
        check({name, "_a"}, o_data_a, ea);
        check({name, "_b"}, o_data_b, eb);
        check({name, "_op"}, o_op, eop);
        check({name, "_start_t1"}, tx_start, 1'b0);
        @(negedge clk);
        check({name, "_start_t2"}, tx_start, 1'b1);
        check({name, "_txdata_t2"}, tx_data, etx);
        @(negedge clk);
        check({name, "_start_t3"}, tx_start, 1'b0);
        check({name, "_txdata_t3"}, tx_data, etx);
    endtask

    task automatic run_frame(input string name, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] opb, input logic [5:0] eop, input logic [7:0] etx);
        pulse_rx(a);
        pulse_rx(b);
        pulse_rx(opb);
        finish_frame(name, a, b, eop, etx);
    endtask

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] opb;
        logic [5:0] op;
        logic [7:0] tx;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic seen;

        vecs[0] = '{"add",      8'h05, 8'h03, 8'h20, 6'h20, 8'h08};
        vecs[1] = '{"sub_mask", 8'h10, 8'h01, 8'hE2, 6'h22, 8'h0F};
        vecs[2] = '{"and",      8'hF0, 8'h3C, 8'h24, 6'h24, 8'h30};
        vecs[3] = '{"or",       8'hF0, 8'h3C, 8'h25, 6'h25, 8'hFC};
        vecs[4] = '{"xor",      8'hF0, 8'h3C, 8'h26, 6'h26, 8'hCC};
        vecs[5] = '{"sra",      8'h80, 8'h02, 8'h03, 6'h03, 8'hE0};
        vecs[6] = '{"srl",      8'h80, 8'h02, 8'h02, 6'h02, 8'h20};
        vecs[7] = '{"nor",      8'h0F, 8'hF0, 8'h27, 6'h27, 8'h00};
        vecs[8] = '{"add_wrap", 8'hFF, 8'h01, 8'h20, 6'h20, 8'h00};
        vecs[9] = '{"sub_neg",  8'h03, 8'h05, 8'h22, 6'h22, 8'hFE};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_a", o_data_a, 8'h00);
        check("rst_b", o_data_b, 8'h00);
        check("rst_op", o_op, 6'h00);
        check("rst_txdata", tx_data, 8'h00);
        check("rst_start", tx_start, 1'b0);
        check("rst_timeout", o_timeout, 1'b0);
        check("rst_overrun", o_overrun, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        // Table of complete frames; the next frame starts right after tx_done.
        foreach (vecs[i]) begin
            run_frame(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].opb, vecs[i].op, vecs[i].tx);
            repeat (2) @(negedge clk);
            pulse_tx_done();
        end

        // Timeout after a lone A byte, then a realigned frame.
        pulse_rx(8'hAA);
        n = 1;
        while (!o_timeout && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", n, TO + 1);
        check("timeout_keeps_a", o_data_a, 8'hAA);
        @(negedge clk);
        check("timeout_one_cycle", o_timeout, 1'b0);
        run_frame("realign", 8'h01, 8'h02, 8'h24, 6'h24, 8'h00);
        pulse_tx_done();

        // B byte lands exactly in the expiry cycle: byte wins.
        pulse_rx(8'h11);
        repeat (TO - 1) @(negedge clk);
        pulse_rx(8'h22);
        check("race_no_timeout1", o_timeout, 1'b0);
        pulse_rx(8'h20);
        check("race_no_timeout2", o_timeout, 1'b0);
        finish_frame("race", 8'h11, 8'h22, 6'h20, 8'h33);
        pulse_tx_done();

        // Overrun during WAIT_TX.
        run_frame("pre_ovr", 8'h05, 8'h06, 8'h20, 6'h20, 8'h0B);
        check("ovr_before", o_overrun, 1'b0);
        pulse_rx(8'h77);
        check("ovr_set", o_overrun, 1'b1);
        check("ovr_a_kept", o_data_a, 8'h05);
        check("ovr_b_kept", o_data_b, 8'h06);
        pulse_tx_done();
        run_frame("post_ovr", 8'h07, 8'h08, 8'h26, 6'h26, 8'h0F);
        check("ovr_sticky", o_overrun, 1'b1);
        pulse_tx_done();
        check("ovr_sticky2", o_overrun, 1'b1);

        // Reset during WAIT_TX, then a late tx_done.
        run_frame("pre_rst", 8'h09, 8'h01, 8'h20, 6'h20, 8'h0A);
        reset = 1'b0;
        @(negedge clk);
        check("mrst_a", o_data_a, 8'h00);
        check("mrst_b", o_data_b, 8'h00);
        check("mrst_op", o_op, 6'h00);
        check("mrst_txdata", tx_data, 8'h00);
        check("mrst_start", tx_start, 1'b0);
        check("mrst_timeout", o_timeout, 1'b0);
        check("mrst_overrun", o_overrun, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        pulse_tx_done();
        seen = 1'b0;
        repeat (3) begin
            seen |= tx_start;
            @(negedge clk);
        end
        check("late_txdone_no_start", seen, 1'b0);
        run_frame("post_rst", 8'h02, 8'h03, 8'h20, 6'h20, 8'h05);
        pulse_tx_done();

        // Reset while in EXEC: no transmit afterwards.
        pulse_rx(8'h04);
        pulse_rx(8'h04);
        pulse_rx(8'h20);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= tx_start;
        end
        check("exec_rst_no_start", seen, 1'b0);
        check("exec_rst_txdata", tx_data, 8'h00);
        run_frame("final", 8'h21, 8'h12, 8'h20, 6'h20, 8'h33);
        pulse_tx_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
